vga_scan_driver: RTL and testbench
==================================

VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP with defaults 16, 96, 48, giving a horizontal total of 800.
REQ-003 SHALL have parameters V_VIS, V_FP, V_SYNC, V_BP with defaults 480, 10, 2, 33, giving a vertical total of 525.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock (50 MHz); one clock, and all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port pixel_color, input, 12 bits: renderer colour; [11:8] R, [7:4] G, [3:0] B.
REQ-007 SHALL have ports VGA_R, VGA_G, VGA_B, output, 4 bits each: registered colour to the DAC.
REQ-008 SHALL have ports VGA_HS, VGA_VS, output, 1 bit each: registered syncs, active-low.
REQ-009 SHALL have ports X_pix, Y_pix, output, 10 bits each: the current horizontal and vertical counter values.
REQ-010 SHALL have ports H_visible, V_visible, output, 1 bit each: high when X_pix < H_VIS or Y_pix < V_VIS respectively.
REQ-011 SHALL have port pixel_clk, output, 1 bit: the 25 MHz pixel phase.
REQ-012 SHALL have port pixel_cnt, output, 10 bits: the number of visible pixels emitted so far on the current line.
REQ-013 SHALL have port frame_start, output, 1 bit: a one-cycle pulse at the start of each frame.

Function
REQ-014 SHALL keep a phase bit ph that toggles every CLOCK_50 cycle; pixel_clk = ph, and one pixel period spans two cycles (ph=0, then ph=1).
REQ-015 SHALL update h_cnt only on edges where ph=1: h_cnt increments, wraps from 799 to 0, and v_cnt increments on that wrap.
REQ-016 SHALL wrap v_cnt from 524 to 0 at the same edge that h_cnt wraps from 799.
REQ-017 SHALL drive X_pix = h_cnt and Y_pix = v_cnt combinationally; both are stable for both cycles of a pixel period.
REQ-018 SHALL sample pixel_color only on ph=1 edges, giving the renderer one full CLOCK_50 cycle after X_pix/Y_pix change (one registered stage is allowed).
REQ-019 SHALL, on the ph=1 edge, load {VGA_R,VGA_G,VGA_B} with pixel_color when H_visible and V_visible are both high, otherwise with 12'h000.
REQ-020 SHALL, on the same ph=1 edge, load VGA_HS low iff 656 <= h_cnt <= 751, and VGA_VS low iff 490 <= v_cnt <= 491, so colour and syncs carry a one-pixel latency relative to the counters.
REQ-021 SHALL, on ph=1 edges, increment pixel_cnt while H_visible and V_visible are both high, saturate it at 640, and clear it to 0 on the h_cnt wrap.
REQ-022 SHALL assert frame_start for exactly one cycle, when h_cnt=0, v_cnt=0 and ph=0.
REQ-023 SHALL use counters at least 10 bits wide and SHALL never produce h_cnt >= 800 or v_cnt >= 525.

Reset
REQ-024 SHALL, in any cycle with reset high, set ph=0, h_cnt=0, v_cnt=0, pixel_cnt=0, RGB=0, VGA_HS=1, VGA_VS=1 and frame_start=0, overriding all other updates.
REQ-025 SHALL, on the first cycle after reset deasserts, assert frame_start with X_pix=0 and Y_pix=0.
REQ-026 SHALL, when reset is applied mid-line or mid-sync, return the syncs to 1 in the next cycle and restart the scan from (0,0) with no partial pulse carried over.

Verification
REQ-027 SHALL cover free run after reset: 800x525x2 = 840000 cycles between consecutive frame_start pulses, and h_cnt wraps every 1600 cycles.
REQ-028 SHALL cover horizontal sync: VGA_HS is low for exactly 192 cycles per line, beginning on the edge where h_cnt goes 656->657 with ph=1.
REQ-029 SHALL cover vertical sync: VGA_VS is low for exactly 2 lines (3200 cycles) per frame, starting at v_cnt=490.
REQ-030 SHALL cover blanking: with pixel_color held at 12'hFFF, RGB is 12'hFFF for (X_pix,Y_pix)=(639,479) and 0 for (640,479) and for (0,480), each observed one pixel later.
REQ-031 SHALL cover latency: pixel_color = 12'hABC applied only while X_pix=5, Y_pix=3 -> RGB = 12'hABC for exactly the pixel period in which X_pix=6.
REQ-032 SHALL cover reset mid-frame: reset pulsed at h_cnt=700, v_cnt=491 -> the next cycle has VGA_VS=1, VGA_HS=1, X_pix=0, Y_pix=0, and frame_start is seen on the first cycle after release.

Source files
------------

// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: pixel phase, h/v scan counters, registered syncs and
// colour, per-line visible-pixel count and a frame-start strobe.
module vga_scan_driver #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [11:0] pixel_color,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [9:0]  X_pix,
  output logic [9:0]  Y_pix,
  output logic        H_visible,
  output logic        V_visible,
  output logic        pixel_clk,
  output logic [9:0]  pixel_cnt,
  output logic        frame_start
);

  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic        r_ph;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  r_pixel_cnt;
  logic [11:0] r_rgb;
  logic        r_hs;
  logic        r_vs;

  logic w_h_vis;
  logic w_v_vis;
  logic w_vis;
  logic w_h_last;
  logic w_v_last;
  logic w_hs_active;
  logic w_vs_active;

  assign w_h_vis     = (r_h_cnt < H_VIS_W);
  assign w_v_vis     = (r_v_cnt < V_VIS_W);
  assign w_vis       = w_h_vis & w_v_vis;
  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_hs_active = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
  assign w_vs_active = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

  // Everything except the phase bit advances only on the second cycle of a pixel,
  // so the renderer sees stable X/Y for a full CLOCK_50 cycle before sampling.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ph        <= 1'b0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_pixel_cnt <= '0;
      r_rgb       <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
    end else begin
      r_ph <= ~r_ph;
      if (r_ph) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
        r_rgb <= w_vis ? pixel_color : 12'h000;
        r_hs  <= ~w_hs_active;
        r_vs  <= ~w_vs_active;
        if (w_h_last)
          r_pixel_cnt <= '0;
        else if (w_vis && (r_pixel_cnt < H_VIS_W))
          r_pixel_cnt <= r_pixel_cnt + 10'd1;
      end
    end
  end

  assign VGA_R     = r_rgb[11:8];
  assign VGA_G     = r_rgb[7:4];
  assign VGA_B     = r_rgb[3:0];
  assign VGA_HS    = r_hs;
  assign VGA_VS    = r_vs;
  assign X_pix     = r_h_cnt;
  assign Y_pix     = r_v_cnt;
  assign H_visible = w_h_vis;
  assign V_visible = w_v_vis;
  assign pixel_clk = r_ph;
  assign pixel_cnt = r_pixel_cnt;

  // Gated by reset so the strobe stays low while reset is held in the (0,0) state.
  assign frame_start = ~reset & ~r_ph & (r_h_cnt == 10'd0) & (r_v_cnt == 10'd0);

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: a default-timing instance for line-level checks and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_s;
  logic [11:0] pc_d, pc_s;

  logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;
  logic       d_hs, d_vs, s_hs, s_vs;
  logic [9:0] d_x, d_y, s_x, s_y, d_pcnt, s_pcnt;
  logic       d_hv, d_vv, s_hv, s_vv, d_pclk, s_pclk, d_fs, s_fs;

  vga_scan_driver dut (
    .CLOCK_50(clk), .reset(rst_d), .pixel_color(pc_d),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .X_pix(d_x), .Y_pix(d_y), .H_visible(d_hv), .V_visible(d_vv),
    .pixel_clk(d_pclk), .pixel_cnt(d_pcnt), .frame_start(d_fs)
  );

  // Small raster: 30 pixels x 12 lines, hsync on h 20..25, vsync on v 8..9.
  vga_scan_driver #(
    .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .CLOCK_50(clk), .reset(rst_s), .pixel_color(pc_s),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .X_pix(s_x), .Y_pix(s_y), .H_visible(s_hv), .V_visible(s_vv),
    .pixel_clk(s_pclk), .pixel_cnt(s_pcnt), .frame_start(s_fs)
  );

  int          vectors = 0;
  int          miscompares = 0;
  string       q_tag[$];
  logic [31:0] q_exp[$];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [31:0] e);
    q_tag.push_back(tag);
    q_exp.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (q_exp.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic wait_xy(input bit sel, input int x, input int y, input string tag);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 20000) begin
      if (sel) hit = (int'(s_x) == x) && (int'(s_y) == y) && !s_pclk;
      else     hit = (int'(d_x) == x) && (int'(d_y) == y) && !d_pclk;
      if (!hit) begin
        step();
        n++;
      end
    end
    push({tag, "_reach"}, 32'd1);
    chk(32'(hit));
  endtask

  initial begin
    int n;
    int lows;
    rst_d = 1'b1;
    rst_s = 1'b1;
    pc_d  = 12'h000;
    pc_s  = 12'hFFF;
    repeat (3) step();

    // Reset state
    push("rst_hs", 32'd1);   chk(32'(d_hs));
    push("rst_vs", 32'd1);   chk(32'(d_vs));
    push("rst_rgb", 32'd0);  chk(32'({d_r, d_g, d_b}));
    push("rst_x", 32'd0);    chk(32'(d_x));
    push("rst_y", 32'd0);    chk(32'(d_y));
    push("rst_pcnt", 32'd0); chk(32'(d_pcnt));
    push("rst_fs", 32'd0);   chk(32'(d_fs));
    push("rst_pclk", 32'd0); chk(32'(d_pclk));

    // First cycle after release carries frame_start at (0,0)
    rst_d = 1'b0;
    #1;
    push("fs_first", 32'd1); chk(32'(d_fs));
    step();
    push("fs_one_cycle", 32'd0); chk(32'(d_fs));
    push("x_stable_ph1", 32'd0); chk(32'(d_x));
    push("pclk_ph1", 32'd1);     chk(32'(d_pclk));

    // Line end: 1599 edges after release is h=799 ph=1, the 1600th wraps
    repeat (1598) step();
    push("x_799", 32'd799);     chk(32'(d_x));
    push("pclk_799", 32'd1);    chk(32'(d_pclk));
    push("pcnt_full", 32'd640); chk(32'(d_pcnt));
    step();
    push("x_wrap", 32'd0);      chk(32'(d_x));
    push("y_inc", 32'd1);       chk(32'(d_y));
    push("pcnt_clr", 32'd0);    chk(32'(d_pcnt));

    // Horizontal sync width and placement
    n = 0;
    while (d_hs !== 1'b0 && n < 2000) begin step(); n++; end
    push("hs_fall_x", 32'd657); chk(32'(d_x));
    push("hs_fall_ph", 32'd0);  chk(32'(d_pclk));
    n = 0;
    while (d_hs === 1'b0 && n < 400) begin step(); n++; end
    push("hs_low_cycles", 32'd192); chk(32'(n));

    // One-pixel colour latency
    wait_xy(1'b0, 5, 3, "lat");
    push("lat_pre", 32'h000); chk(32'({d_r, d_g, d_b}));
    pc_d = 12'hABC;
    step();
    push("lat_x5_ph1", 32'd5);   chk(32'(d_x));
    push("lat_rgb_x5", 32'h000); chk(32'({d_r, d_g, d_b}));
    step();
    pc_d = 12'h000;
    push("lat_x6", 32'd6);       chk(32'(d_x));
    push("lat_rgb_x6a", 32'hABC); chk(32'({d_r, d_g, d_b}));
    step();
    push("lat_rgb_x6b", 32'hABC); chk(32'({d_r, d_g, d_b}));
    step();
    push("lat_x7", 32'd7);       chk(32'(d_x));
    push("lat_rgb_x7", 32'h000); chk(32'({d_r, d_g, d_b}));

    // Small instance: frame period 30*12*2 cycles
    step();
    rst_s = 1'b0;
    #1;
    push("s_fs_first", 32'd1); chk(32'(s_fs));
    n = 0;
    do begin step(); n++; end while (s_fs !== 1'b1 && n < 2000);
    push("s_frame_cycles", 32'd720); chk(32'(n));

    // Blanking edges with full-white input
    wait_xy(1'b1, 15, 5, "blank_a");
    repeat (2) step();
    push("blank_x16", 32'd16);      chk(32'(s_x));
    push("rgb_last_vis", 32'hFFF);  chk(32'({s_r, s_g, s_b}));
    push("pcnt_line", 32'd16);      chk(32'(s_pcnt));
    repeat (2) step();
    push("rgb_h_blank", 32'h000);   chk(32'({s_r, s_g, s_b}));
    push("pcnt_hold", 32'd16);      chk(32'(s_pcnt));
    wait_xy(1'b1, 0, 6, "blank_b");
    repeat (2) step();
    push("blank_x1", 32'd1);        chk(32'(s_x));
    push("rgb_v_blank", 32'h000);   chk(32'({s_r, s_g, s_b}));

    // Vertical sync placement and width
    n = 0;
    while (s_vs !== 1'b0 && n < 2000) begin step(); n++; end
    push("vs_fall_y", 32'd8); chk(32'(s_y));
    push("vs_fall_x", 32'd1); chk(32'(s_x));
    n = 0;
    while (s_vs === 1'b0 && n < 400) begin step(); n++; end
    push("vs_low_cycles", 32'd120); chk(32'(n));

    // Reset inside both sync pulses
    wait_xy(1'b1, 22, 9, "mid");
    push("mid_hs_low", 32'd0); chk(32'(s_hs));
    push("mid_vs_low", 32'd0); chk(32'(s_vs));
    rst_s = 1'b1;
    step();
    push("mid_rst_hs", 32'd1); chk(32'(s_hs));
    push("mid_rst_vs", 32'd1); chk(32'(s_vs));
    push("mid_rst_x", 32'd0);  chk(32'(s_x));
    push("mid_rst_y", 32'd0);  chk(32'(s_y));
    push("mid_rst_fs", 32'd0); chk(32'(s_fs));
    rst_s = 1'b0;
    #1;
    push("mid_fs_after", 32'd1); chk(32'(s_fs));
    lows = 0;
    repeat (40) begin
      step();
      if (s_hs !== 1'b1 || s_vs !== 1'b1) lows++;
    end
    push("mid_no_partial_sync", 32'd0); chk(32'(lows));
    push("mid_x_after", 32'd20);        chk(32'(s_x));

    if (q_exp.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
